// File: rtl/shift_rows_pipe_if.sv
// Stream bundle for the ShiftRows stage. It carries the input beat (with its direction
// and tag), the output beat, and the ready/valid handshake on both sides.
interface shift_rows_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) ();
  localparam int W = 32 * NB;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_inv;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  // Block side: consumes input beats and produces output beats
  modport slave (
    input  in_valid, in_data, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  // Environment side: produces input beats and consumes output beats
  modport master (
    output in_valid, in_data, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows stage for Rijndael states of 4, 6 or 8 columns.
// The row rotation is pure wiring on the input side. Its result is written into a
// 2-entry FIFO, which gives 1-cycle latency, full throughput and registered outputs.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  shift_rows_pipe_if.slave bus
);
  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_badNb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Rotation amount of each row. The 8-column Rijndael variant moves rows 2 and 3 further.
  function automatic int rowShift(input int r);
    int s;
    s = r;
    if (NB == 8 && r >= 2) s = r + 1;
    return s;
  endfunction

  logic [W-1:0]     w_fwdData;
  logic [W-1:0]     w_invData;
  logic [W-1:0]     w_xformData;
  logic             w_push;
  logic             w_pop;

  logic [W-1:0]     r_memData [2];
  logic [TAG_W-1:0] r_memTag  [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_cnt;

  // Byte i of the state is row i%4, column i/4. Every output byte is selected from a
  // fixed source byte, so both directions are only routing; no adders are needed.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S  = rowShift(r);
      localparam int FC = (c + S) % NB;
      localparam int IC = (c - S + NB) % NB;
      assign w_fwdData[W-1-8*(4*c+r) -: 8] = bus.in_data[W-1-8*(4*FC+r) -: 8];
      assign w_invData[W-1-8*(4*c+r) -: 8] = bus.in_data[W-1-8*(4*IC+r) -: 8];
    end
  end

  assign w_xformData = bus.in_inv ? w_invData : w_fwdData;

  assign bus.in_ready  = (r_cnt != 2'd2);
  assign bus.out_valid = (r_cnt != 2'd0);
  assign bus.out_data  = r_memData[r_rdPtr];
  assign bus.out_tag   = r_memTag[r_rdPtr];

  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;

  // FIFO storage and pointers. Reset clears the entries so that the outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_memData[0] <= '0;
      r_memData[1] <= '0;
      r_memTag[0]  <= '0;
      r_memTag[1]  <= '0;
      r_wrPtr      <= 1'b0;
      r_rdPtr      <= 1'b0;
    end else begin
      if (w_push) begin
        r_memData[r_wrPtr] <= w_xformData;
        r_memTag[r_wrPtr]  <= bus.in_tag;
        r_wrPtr            <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
    end
  end

  // Occupancy. A simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule
